// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: MFP68901 interrupt controller stage.
// Latches per-channel event pulses into IPR, masks and prioritises the 16
// channels against the in-service level, drives IRQ and returns the vector
// on the rising edge of the CPU acknowledge.
module mfp_irq_ctrl #(
  parameter int unsigned NCH     = 16,
  parameter bit          SPUR_EN = 1'b0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NCH-1:0]  IRQ_IN,
  input  logic [3:0]      ADDR,
  input  logic            REG_WE,
  input  logic [7:0]      DAT_I,
  output logic [7:0]      DAT_O,
  input  logic            IACK,
  output logic            IRQ,
  output logic [7:0]      VECTOR,
  output logic            VECTOR_VALID
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned HW = NCH / 2;

  localparam logic [3:0] A_IERA = 4'd0;
  localparam logic [3:0] A_IERB = 4'd1;
  localparam logic [3:0] A_IPRA = 4'd2;
  localparam logic [3:0] A_IPRB = 4'd3;
  localparam logic [3:0] A_ISRA = 4'd4;
  localparam logic [3:0] A_ISRB = 4'd5;
  localparam logic [3:0] A_IMRA = 4'd6;
  localparam logic [3:0] A_IMRB = 4'd7;
  localparam logic [3:0] A_VR   = 4'd8;

  // Register state; vr_q holds VR[7:3], vr_q[0] is the S bit.
  logic [NCH-1:0] ier_q, ipr_q, isr_q, imr_q;
  logic [4:0]     vr_q;
  logic           irq_q;
  logic [7:0]     vector_q;
  logic           vv_q;
  logic           iack_q, iack_lo_q, smp_vld_q;

  // Next-state values
  logic [NCH-1:0] ier_n, ipr_n, isr_n, imr_n;
  logic [4:0]     vr_n;
  logic [7:0]     vector_n;
  logic           vv_n;

  // Prioritisation terms
  logic [NCH-1:0] pend;
  logic           p_any, s_any, irq_c, ack_c;
  logic [CW-1:0]  h_idx, s_idx;
  logic [NCH-1:0] half_mask, wdat;

  // Index of the most significant set bit (0 when none set)
  function automatic logic [CW-1:0] msb_idx(input logic [NCH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (v[i]) r = CW'(i);
    end
    return r;
  endfunction

  // Request and acknowledge decision from the current register state
  always_comb begin
    pend  = ipr_q & imr_q;
    p_any = |pend;
    s_any = |isr_q;
    h_idx = msb_idx(pend);
    s_idx = msb_idx(isr_q);
    irq_c = p_any && (!s_any || (h_idx > s_idx));
    // acknowledge only on a low->high transition seen after reset release
    ack_c = iack_q & iack_lo_q;
  end

  // Next register state: write first, then acknowledge, then event set
  always_comb begin
    ier_n    = ier_q;
    ipr_n    = ipr_q;
    isr_n    = isr_q;
    imr_n    = imr_q;
    vr_n     = vr_q;
    vector_n = vector_q;
    vv_n     = 1'b0;
    half_mask = ADDR[0] ? {{HW{1'b0}}, {HW{1'b1}}} : {{HW{1'b1}}, {HW{1'b0}}};
    wdat      = {2{DAT_I}};

    if (REG_WE) begin
      case (ADDR)
        A_IERA, A_IERB: begin
          ier_n = (ier_q & ~half_mask) | (wdat & half_mask);
          ipr_n = ipr_n & ier_n;
        end
        A_IPRA, A_IPRB: ipr_n = ipr_q & (wdat | ~half_mask);
        A_ISRA, A_ISRB: isr_n = isr_q & (wdat | ~half_mask);
        A_IMRA, A_IMRB: imr_n = (imr_q & ~half_mask) | (wdat & half_mask);
        A_VR: begin
          vr_n = DAT_I[7:3];
          if (!DAT_I[3]) isr_n = '0;
        end
        default: ;
      endcase
    end

    if (ack_c) begin
      if (p_any) begin
        ipr_n[h_idx] = 1'b0;
        if (vr_n[0]) isr_n[h_idx] = 1'b1;
        vector_n = {vr_n[4:1], 4'(h_idx)};
        vv_n     = 1'b1;
      end else if (SPUR_EN) begin
        vector_n = {vr_n[4:1], 4'hF};
        vv_n     = 1'b1;
      end
    end

    // an incoming event beats any clear of the same bit this cycle
    ipr_n = ipr_n | (IRQ_IN & ier_q);
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ier_q     <= '0;
      ipr_q     <= '0;
      isr_q     <= '0;
      imr_q     <= '0;
      vr_q      <= '0;
      irq_q     <= 1'b0;
      vector_q  <= '0;
      vv_q      <= 1'b0;
      iack_q    <= 1'b0;
      iack_lo_q <= 1'b0;
      smp_vld_q <= 1'b0;
    end else begin
      ier_q     <= ier_n;
      ipr_q     <= ipr_n;
      isr_q     <= isr_n;
      imr_q     <= imr_n;
      vr_q      <= vr_n;
      irq_q     <= irq_c;
      vector_q  <= vector_n;
      vv_q      <= vv_n;
      iack_q    <= IACK;
      // a low sample only counts once a real sample preceded it
      iack_lo_q <= ~iack_q & smp_vld_q;
      smp_vld_q <= 1'b1;
    end
  end

  // Register read mux
  always_comb begin
    case (ADDR)
      A_IERA:  DAT_O = ier_q[NCH-1:HW];
      A_IERB:  DAT_O = ier_q[HW-1:0];
      A_IPRA:  DAT_O = ipr_q[NCH-1:HW];
      A_IPRB:  DAT_O = ipr_q[HW-1:0];
      A_ISRA:  DAT_O = isr_q[NCH-1:HW];
      A_ISRB:  DAT_O = isr_q[HW-1:0];
      A_IMRA:  DAT_O = imr_q[NCH-1:HW];
      A_IMRB:  DAT_O = imr_q[HW-1:0];
      A_VR:    DAT_O = {vr_q, 3'b000};
      default: DAT_O = 8'h00;
    endcase
  end

  assign IRQ          = irq_q;
  assign VECTOR       = vector_q;
  assign VECTOR_VALID = vv_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Bench for mfp_irq_ctrl: directed vector table, corner sequences and
// randomized traffic against a behavioural model; two instances cover
// SPUR_EN = 0 and 1 on shared inputs.
module tb_mfp_irq_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [15:0] IRQ_IN;
  logic [3:0]  ADDR;
  logic        REG_WE;
  logic [7:0]  DAT_I;
  logic        IACK;
  logic [7:0]  dat_o0, dat_o1, vec0, vec1;
  logic        irq0, irq1, vv0, vv1;

  int n_vec = 0;
  int n_err = 0;

  mfp_irq_ctrl #(.NCH(16), .SPUR_EN(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .IRQ_IN(IRQ_IN), .ADDR(ADDR), .REG_WE(REG_WE),
    .DAT_I(DAT_I), .DAT_O(dat_o0), .IACK(IACK), .IRQ(irq0), .VECTOR(vec0),
    .VECTOR_VALID(vv0));

  mfp_irq_ctrl #(.NCH(16), .SPUR_EN(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .IRQ_IN(IRQ_IN), .ADDR(ADDR), .REG_WE(REG_WE),
    .DAT_I(DAT_I), .DAT_O(dat_o1), .IACK(IACK), .IRQ(irq1), .VECTOR(vec1),
    .VECTOR_VALID(vv1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [15:0] m_ier, m_ipr, m_isr, m_imr;
  logic [7:0]  m_vr;
  logic        m_irq;
  logic [7:0]  m_vec [2];
  logic        m_vv [2];
  int          m_nsamp;
  logic        m_s_last, m_s_prev;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  dat;
    logic [15:0] irqin;
    logic        iack;
    logic        e_irq;
    logic        e_vv;
    logic [7:0]  e_vec;
    logic [7:0]  e_dat;
  } row_t;

  row_t tbl [29];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int hi(input logic [15:0] v);
    int r = -1;
    for (int i = 0; i < 16; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    logic [15:0] r;
    if (a == 4'd8) return m_vr;
    if (a > 4'd8) return 8'h00;
    case (a[3:1])
      3'd0:    r = m_ier;
      3'd1:    r = m_ipr;
      3'd2:    r = m_isr;
      default: r = m_imr;
    endcase
    return a[0] ? r[7:0] : r[15:8];
  endfunction

  task automatic model_reset();
    m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_vr = '0;
    m_irq = 1'b0; m_nsamp = 0; m_s_last = 1'b0; m_s_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin m_vec[k] = '0; m_vv[k] = 1'b0; end
  endtask

  // One clock edge of the controller, from the register-level rules
  task automatic model_step(input logic we, input logic [3:0] addr, input logic [7:0] dat,
                            input logic [15:0] irqin, input logic iack);
    logic [15:0] p, msk, w, ier_n, ipr_n, isr_n, imr_n;
    logic [7:0]  vr_n;
    int h, s;
    bit ack;
    p   = m_ipr & m_imr;
    h   = hi(p);
    s   = hi(m_isr);
    ack = (m_nsamp >= 2) && m_s_last && !m_s_prev;
    m_s_prev = m_s_last; m_s_last = iack; m_nsamp++;
    msk = addr[0] ? 16'h00FF : 16'hFF00;
    w   = {dat, dat};
    ier_n = m_ier; ipr_n = m_ipr; isr_n = m_isr; imr_n = m_imr; vr_n = m_vr;
    if (we) begin
      if (addr <= 4'd1) begin
        ier_n = (m_ier & ~msk) | (w & msk);
        ipr_n = ipr_n & ier_n;
      end else if (addr <= 4'd3) ipr_n = m_ipr & (w | ~msk);
      else if (addr <= 4'd5) isr_n = m_isr & (w | ~msk);
      else if (addr <= 4'd7) imr_n = (m_imr & ~msk) | (w & msk);
      else if (addr == 4'd8) begin
        vr_n = dat & 8'hF8;
        if (!dat[3]) isr_n = '0;
      end
    end
    m_vv[0] = 1'b0; m_vv[1] = 1'b0;
    if (ack && p != 0) begin
      ipr_n[h] = 1'b0;
      if (vr_n[3]) isr_n[h] = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_vec[k] = {vr_n[7:4], 4'(h)};
        m_vv[k]  = 1'b1;
      end
    end else if (ack) begin
      m_vec[1] = {vr_n[7:4], 4'hF};
      m_vv[1]  = 1'b1;
    end
    ipr_n = ipr_n | (irqin & m_ier);
    m_irq = (p != 0) && (h > s);
    m_ier = ier_n; m_ipr = ipr_n; m_isr = isr_n; m_imr = imr_n; m_vr = vr_n;
  endtask

  task automatic compare_all();
    chk("irq0", 16'(irq0), 16'(m_irq));
    chk("irq1", 16'(irq1), 16'(m_irq));
    chk("vv0", 16'(vv0), 16'(m_vv[0]));
    chk("vv1", 16'(vv1), 16'(m_vv[1]));
    chk("vec0", 16'(vec0), 16'(m_vec[0]));
    chk("vec1", 16'(vec1), 16'(m_vec[1]));
    chk("dat0", 16'(dat_o0), 16'(m_read(ADDR)));
    chk("dat1", 16'(dat_o1), 16'(m_read(ADDR)));
  endtask

  // Drive one cycle at the falling edge, step the model at the rising edge
  task automatic cyc(input logic we, input logic [3:0] addr, input logic [7:0] dat,
                     input logic [15:0] irqin, input logic iack);
    @(negedge CLK);
    REG_WE = we; ADDR = addr; DAT_I = dat; IRQ_IN = irqin; IACK = iack;
    @(posedge CLK);
    model_step(we, addr, dat, irqin, iack);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; REG_WE = 1'b0; ADDR = 4'd0; DAT_I = 8'h00; IRQ_IN = '0; IACK = 1'b0;
    model_reset();
    #1;
    chk("rst_irq", 16'(irq0), 16'h0);
    chk("rst_vv", 16'(vv1), 16'h0);
    chk("rst_vec", 16'(vec0), 16'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    logic lvl;
    RST_N = 1'b0; REG_WE = 1'b0; ADDR = 4'd0; DAT_I = 8'h00; IRQ_IN = '0; IACK = 1'b0;

    //              we    addr   dat    irqin     iack  irq   vv    vec    dat_o
    tbl[0]  = '{1'b1, 4'd0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20};
    tbl[1]  = '{1'b1, 4'd6, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20};
    tbl[2]  = '{1'b1, 4'd8, 8'h40, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40};
    tbl[3]  = '{1'b0, 4'd2, 8'h00, 16'h2000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20};
    tbl[4]  = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h20};
    tbl[5]  = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20};
    tbl[6]  = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h4D, 8'h00};
    tbl[7]  = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h4D, 8'h00};
    tbl[8]  = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h00};
    tbl[9]  = '{1'b1, 4'd8, 8'h48, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h48};
    tbl[10] = '{1'b1, 4'd1, 8'h28, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h28};
    tbl[11] = '{1'b1, 4'd7, 8'h28, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h28};
    tbl[12] = '{1'b0, 4'd3, 8'h00, 16'h0020, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h20};
    tbl[13] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h4D, 8'h20};
    tbl[14] = '{1'b0, 4'd5, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h45, 8'h20};
    tbl[15] = '{1'b0, 4'd3, 8'h00, 16'h0008, 1'b0, 1'b0, 1'b0, 8'h45, 8'h08};
    tbl[16] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h45, 8'h08};
    tbl[17] = '{1'b0, 4'd2, 8'h00, 16'h2000, 1'b0, 1'b0, 1'b0, 8'h45, 8'h20};
    tbl[18] = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h45, 8'h20};
    tbl[19] = '{1'b0, 4'd2, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h45, 8'h20};
    tbl[20] = '{1'b0, 4'd4, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h4D, 8'h20};
    tbl[21] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h08};
    tbl[22] = '{1'b1, 4'd5, 8'hDF, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h00};
    tbl[23] = '{1'b0, 4'd4, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h20};
    tbl[24] = '{1'b1, 4'd4, 8'hDF, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h00};
    tbl[25] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h4D, 8'h08};
    tbl[26] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h4D, 8'h08};
    tbl[27] = '{1'b0, 4'd5, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h43, 8'h08};
    tbl[28] = '{1'b0, 4'd3, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h43, 8'h00};

    // Directed table: basic request/ack, then in-service nesting with S=1
    do_reset();
    for (int i = 0; i < 29; i++) begin
      cyc(tbl[i].we, tbl[i].addr, tbl[i].dat, tbl[i].irqin, tbl[i].iack);
      chk($sformatf("t%0d_irq", i), 16'(irq0), 16'(tbl[i].e_irq));
      chk($sformatf("t%0d_vv", i), 16'(vv0), 16'(tbl[i].e_vv));
      chk($sformatf("t%0d_vec", i), 16'(vec0), 16'(tbl[i].e_vec));
      chk($sformatf("t%0d_dat", i), 16'(dat_o0), 16'(tbl[i].e_dat));
    end

    // Masking holds the pend; disabling drops it
    do_reset();
    cyc(1'b1, 4'd1, 8'h01, 16'h0000, 1'b0);
    cyc(1'b1, 4'd7, 8'h00, 16'h0000, 1'b0);
    cyc(1'b0, 4'd3, 8'h00, 16'h0001, 1'b0);
    chk("mask_iprb", 16'(dat_o0), 16'h01);
    cyc(1'b0, 4'd3, 8'h00, 16'h0000, 1'b0);
    chk("mask_irq", 16'(irq0), 16'h0);
    cyc(1'b1, 4'd7, 8'h01, 16'h0000, 1'b0);
    cyc(1'b0, 4'd3, 8'h00, 16'h0000, 1'b0);
    chk("unmask_irq", 16'(irq0), 16'h1);
    cyc(1'b1, 4'd1, 8'h00, 16'h0000, 1'b0);
    cyc(1'b0, 4'd3, 8'h00, 16'h0000, 1'b0);
    chk("ier_clr_iprb", 16'(dat_o0), 16'h00);
    chk("ier_clr_irq", 16'(irq0), 16'h0);

    // Event set beats IPR write clear and IACK clear
    do_reset();
    cyc(1'b1, 4'd0, 8'h80, 16'h0000, 1'b0);
    cyc(1'b1, 4'd6, 8'h80, 16'h0000, 1'b0);
    cyc(1'b1, 4'd8, 8'h40, 16'h0000, 1'b0);
    cyc(1'b0, 4'd2, 8'h00, 16'h8000, 1'b0);
    chk("pend15", 16'(dat_o0), 16'h80);
    cyc(1'b1, 4'd2, 8'h00, 16'h8000, 1'b0);
    chk("iprwr_vs_set", 16'(dat_o0), 16'h80);
    cyc(1'b1, 4'd2, 8'h7F, 16'h0000, 1'b0);
    chk("iprwr_clr", 16'(dat_o0), 16'h00);
    cyc(1'b0, 4'd2, 8'h00, 16'h8000, 1'b0);
    cyc(1'b0, 4'd2, 8'h00, 16'h0000, 1'b1);
    cyc(1'b0, 4'd2, 8'h00, 16'h8000, 1'b1);
    chk("iack_vs_set_vv", 16'(vv0), 16'h1);
    chk("iack_vs_set_vec", 16'(vec0), 16'h4F);
    chk("iack_vs_set_ipra", 16'(dat_o0), 16'h80);
    cyc(1'b0, 4'd2, 8'h00, 16'h0000, 1'b0);

    // Spurious acknowledge with nothing pending
    do_reset();
    cyc(1'b1, 4'd8, 8'h50, 16'h0000, 1'b0);
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b1);
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b1);
    chk("spur0_vv", 16'(vv0), 16'h0);
    chk("spur0_vec", 16'(vec0), 16'h00);
    chk("spur1_vv", 16'(vv1), 16'h1);
    chk("spur1_vec", 16'(vec1), 16'h5F);
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b0);
    chk("spur1_vv_end", 16'(vv1), 16'h0);

    // Asynchronous reset in the middle of an acknowledge
    do_reset();
    cyc(1'b1, 4'd0, 8'h80, 16'h0000, 1'b0);
    cyc(1'b1, 4'd6, 8'h80, 16'h0000, 1'b0);
    cyc(1'b1, 4'd8, 8'h48, 16'h0000, 1'b0);
    cyc(1'b0, 4'd4, 8'h00, 16'h8000, 1'b0);
    cyc(1'b0, 4'd4, 8'h00, 16'h0000, 1'b1);
    cyc(1'b0, 4'd4, 8'h00, 16'h8000, 1'b1);
    chk("pre_rst_vv", 16'(vv0), 16'h1);
    chk("pre_rst_isra", 16'(dat_o0), 16'h80);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("arst_irq", 16'(irq0), 16'h0);
    chk("arst_vv0", 16'(vv0), 16'h0);
    chk("arst_vv1", 16'(vv1), 16'h0);
    chk("arst_vec", 16'(vec0), 16'h00);
    for (int a = 0; a < 9; a++) begin
      ADDR = 4'(a);
      #1;
      chk($sformatf("arst_reg%0d", a), 16'(dat_o0), 16'h00);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b1);
      chk($sformatf("held_iack_vv%0d", i), 16'(vv1), 16'h0);
    end
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b0);
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b1);
    cyc(1'b0, 4'd8, 8'h00, 16'h0000, 1'b1);
    chk("post_rst_edge_vv", 16'(vv1), 16'h1);
    chk("post_rst_edge_vec", 16'(vec1), 16'h0F);

    // Randomized traffic against the model
    do_reset();
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic        we;
      logic [3:0]  a;
      logic [7:0]  d;
      logic [15:0] ev;
      if ($urandom_range(0, 3) == 0) lvl = ~lvl;
      we = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom_range(0, 9));
      d  = 8'($urandom);
      ev = 16'($urandom & $urandom & $urandom);
      cyc(we, a, d, ev, lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
